// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: one-entry instruction fetch buffer between the core fetch port and a req/ack memory bus
module inst_fetch_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              stallreq_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_err_i,
    output logic              bus_err_o
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t              r_state, w_next;
    logic                r_buf_valid;
    logic [ADDR_W-1:0]   r_buf_tag;
    logic [DATA_W-1:0]   r_buf_data;
    logic                r_discard;
    logic [15:0]         r_cnt;
    logic                w_hit, w_miss, w_ack_ok, w_fail, w_done, w_drop;
    assign w_hit    = cpu_ce_i && r_buf_valid && r_buf_tag == cpu_addr_i && !flush_i;
    assign w_miss   = cpu_ce_i && !w_hit;
    assign w_ack_ok = r_state == BUSY && mem_ack_i && !mem_err_i;
    assign w_fail   = r_state == BUSY && (mem_err_i || (r_cnt == 16'(TIMEOUT - 1) && !mem_ack_i));
    assign w_done   = w_ack_ok || w_fail;
    assign w_drop   = r_discard || flush_i;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next state: a miss in IDLE starts a fetch, BUSY ends on ack, error or timeout
    always_comb begin
        w_next = r_state == IDLE ? (w_miss ? BUSY : IDLE) : (w_done ? IDLE : BUSY);
    end
    // core-side outputs: buffer data on a hit, stall on any enabled non-hit; silent in reset
    always_comb begin
        cpu_data_o = (!rst && w_hit) ? r_buf_data : '0;
        stallreq_o = !rst && w_miss;
    end
    // bus side: request/address held for the whole transaction, timeout counter, flush-discard flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            bus_err_o  <= 1'b0;
            r_cnt      <= '0;
            r_discard  <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            if (r_state == IDLE && w_miss) begin
                mem_addr_o <= cpu_addr_i;
                mem_req_o  <= 1'b1;
                r_cnt      <= '0;
            end
            if (r_state == BUSY) r_cnt <= r_cnt + 16'd1;
            if (w_done) begin
                mem_req_o <= 1'b0;
                r_discard <= 1'b0;
                bus_err_o <= w_fail && !w_drop;
            end else if (r_state == BUSY && flush_i) begin
                r_discard <= 1'b1;
            end
        end
    end
    // fetch buffer: filled with bus data or a NOP when a fetch completes, unless flushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else begin
            if (w_done && !w_drop) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= mem_addr_o;
                r_buf_data  <= w_ack_ok ? mem_data_i : '0;
            end
            if (flush_i) r_buf_valid <= 1'b0;
        end
    end
endmodule
